alu_serial_sched: RTL
=====================

# alu_serial_sched

Round-robin command scheduler for the serial ALU. It accepts 8-bit arithmetic commands from up to N_REQ requesters and grants one at a time. For each grant it serialises a framed 32-bit command word onto the ALU's single-bit input, then captures the 16-bit result and returns it to the granted requester tagged with its index. It owns the ALU's `data_in` line exclusively and sits between the requesting blocks and the ALU.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `GAP`, 2: idle cycles (line held 0) after each transaction, at least 1.

- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req` in N_REQ: request level per requester; held until granted.
- `req_a` in N_REQ*8: operand A per requester; slice i is bits [8i+7:8i].
- `req_b` in N_REQ*8: operand B per requester, same packing.
- `req_op` in N_REQ*3: opcode per requester; slice i is [3i+2:3i].
- `gnt` out N_REQ: one-hot, one-cycle pulse; the command is sampled in this cycle.
- `busy` out 1: high in every state except IDLE.
- `alu_data_in` out 1: registered serial line to the ALU.
- `alu_res_out` in 16: ALU result.
- `resp_valid` out 1: one-cycle pulse carrying the result.
- `resp_id` out $clog2(N_REQ): index of the requester served.
- `resp_data` out 16: captured result.
- `resp_stale` out 1: 1 when op is 5..7 (ALU holds its previous result).

## Operation
- **Reset values** while `rst`=0: all outputs 0, RR pointer at 0, state FLUSH, any in-flight transaction dropped with no response.
- **States:** FLUSH → IDLE → PRE → DATA → CAPT → GAPW → IDLE.
- **FLUSH:** lasts 40 cycles after reset release with `alu_data_in`=0 and `busy`=1. This drains any frame the ALU was mid-way through. The ALU then sees execute=0 bits and leaves its result unchanged.
- **IDLE:** if any `req` bit is high, grant the first requester at or after the RR pointer (wrapping) and pulse `gnt`. Latch that requester's A, B, op and id. Move the pointer to granted index+1 mod N_REQ, then go to PRE. If no `req` is high, stay in IDLE.
- **Command word W:**
  - W[31:24]=A, W[23:16]=B, W[15:11]=0.
  - W[10:8]=op, W[7:1]=0, W[0]=1 (execute is always set).
- **PRE:** drive the preamble 1,0,1,0 for 4 cycles.
- **DATA:** drive W[0] through W[31], LSB first, for 32 cycles. A 5-bit counter wraps to 0 at the end of DATA.
- **CAPT:** drive 0 for 1 cycle and register `alu_res_out` into `resp_data`.
- **Response:** `resp_valid` pulses in the cycle after CAPT, together with `resp_id`. `resp_stale` is set when op ≥ 5.
- **GAPW:** drive 0 for GAP cycles, then return to IDLE.
- **Requests:**
  - Dropping `req` before it is granted is legal; the dropped request is not served.
  - `req` changes during a transaction have no effect until IDLE.
  - The latched command is immune to later changes on the `req_*` inputs.
- **Op results (ALU semantics):**
  - op 0 → 0.
  - op 1 → A+B.
  - op 2 → A−B, mod 2^16.
  - op 3 → A*B.
  - op 4 → A/B, or 16'hDEAD when B=0.
  - op 5..7 → previous result.

## Timing
- Let G be the `gnt` cycle (cycle 0).
- `alu_data_in` carries:
  - preamble in cycles G+1..G+4;
  - W[k] in cycle G+5+k, up to W[31] in G+36;
  - 0 in G+37.
- The ALU updates `res_out` at the end of G+36. The scheduler samples it in G+37.
- `resp_valid` is asserted in G+38: 38 cycles of latency.
- GAPW covers G+38..G+37+GAP; the earliest next `gnt` is G+38+GAP (G+40 with the default GAP).
- `busy` is high from G+1 through G+37+GAP.
- `alu_data_in` is 0 in every cycle outside PRE and DATA.

## Test plan
- **Reset flush:** release `rst` with `req[0]`=1 held → no `gnt` before cycle 40. `gnt[0]` pulses in cycle 40 and `alu_data_in` stays 0 throughout.
- **Single add:** req 0, A=8'd200, B=8'd100, op=1 → the line shows 1010 followed by W=32'hC8640101 LSB-first. `resp_valid` at G+38 with `resp_data`=16'd300, `resp_id`=0, `resp_stale`=0.
- **Round-robin:** all 4 requesters held high with distinct ops → grants in order 0,1,2,3,0. Grants are spaced exactly 40 cycles apart, and each `resp_id` matches its grant.
- **Divide by zero and stale:**
  - A=8'd9, B=8'd0, op=4 → 16'hDEAD.
  - Then A=8'd3, B=8'd3, op=6 → `resp_data`=16'hDEAD with `resp_stale`=1.
- **Multiply and subtract wrap:**
  - A=8'd255, B=8'd255, op=3 → 16'd65025.
  - A=8'd1, B=8'd2, op=2 → 16'hFFFF.
- **Mid-frame reset:** assert `rst` at G+20 for 1 cycle → no `resp_valid`. After release, FLUSH runs for 40 cycles, then a new add (A=8'd5, B=8'd7, op=1) returns 16'd12.

Source files
------------

// File: rtl/alu_serial_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_serial_sched_if
// Purpose  : Bundles the requester bus, response bus and serial ALU link of
//            alu_serial_sched into one interface.
// Signals  : req/req_a/req_b/req_op  - per-requester command inputs
//            gnt                     - one-hot grant pulse
//            busy                    - scheduler not in IDLE
//            alu_data_in             - serial line to the ALU
//            alu_res_out             - ALU result
//            resp_valid/id/data/stale- response to the served requester
// Modports : slave  - scheduler side
//            master - requesters + ALU side
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface alu_serial_sched_if #(
   parameter int N_REQ = 4
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]   req;
   logic [N_REQ*8-1:0] req_a;
   logic [N_REQ*8-1:0] req_b;
   logic [N_REQ*3-1:0] req_op;
   logic [N_REQ-1:0]   gnt;
   logic               busy;
   logic               alu_data_in;
   logic [15:0]        alu_res_out;
   logic               resp_valid;
   logic [ID_W-1:0]    resp_id;
   logic [15:0]        resp_data;
   logic               resp_stale;

   modport slave (
      input  req, req_a, req_b, req_op, alu_res_out,
      output gnt, busy, alu_data_in, resp_valid, resp_id, resp_data, resp_stale
   );

   modport master (
      output req, req_a, req_b, req_op, alu_res_out,
      input  gnt, busy, alu_data_in, resp_valid, resp_id, resp_data, resp_stale
   );
endinterface
`default_nettype wire

// File: rtl/alu_serial_sched.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_serial_sched
// Purpose  : Round-robin scheduler for the serial ALU. Grants one requester at
//            a time, shifts a framed 32-bit command word (preamble 1010, then
//            the word LSB first) onto the ALU input, captures the 16-bit result
//            and returns it tagged with the requester index.
// Ports    : clk - rising-edge clock
//            rst - synchronous active-low reset
//            bus - alu_serial_sched_if.slave (requests, grant, serial link,
//                  response)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module alu_serial_sched #(
   parameter int N_REQ = 4,
   parameter int GAP   = 2
) (
   input  wire logic           clk,
   input  wire logic           rst,
   alu_serial_sched_if.slave   bus
);
   localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int FLUSH_CYC = 40;
   localparam int PRE_CYC   = 4;
   // One counter serves FLUSH, PRE and GAPW; it must hold both 39 and GAP-1.
   localparam int CNT_W     = ($clog2(GAP) > 6) ? $clog2(GAP) : 6;

   localparam logic [2:0] S_FLUSH = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_PRE   = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_CAPT  = 3'd4;
   localparam logic [2:0] S_GAPW  = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [4:0]       bit_q,   bit_d;
   logic [ID_W-1:0]  ptr_q,   ptr_d;
   logic             line_q,  line_d;

   logic [7:0]       a_q, b_q;
   logic [2:0]       op_q;
   logic [ID_W-1:0]  id_q;

   logic             resp_valid_q;
   logic [ID_W-1:0]  resp_id_q;
   logic [15:0]      resp_data_q;
   logic             resp_stale_q;

   logic             any_req;
   logic [ID_W-1:0]  sel;
   int               rr_idx;
   logic [N_REQ-1:0] gnt_w;
   logic             busy_w;
   logic             take;
   logic [31:0]      cmd_word;

   assign cmd_word = {a_q, b_q, 5'd0, op_q, 7'd0, 1'b1};
   assign take     = (state_q == S_IDLE) && any_req;

   // Round-robin pick: scan from the pointer downwards in priority so the
   // requester closest to the pointer is assigned last and wins.
   always_comb begin
      any_req = 1'b0;
      sel     = ptr_q;
      rr_idx  = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         rr_idx = (int'(ptr_q) + k) % N_REQ;
         if (bus.req[rr_idx]) begin
            any_req = 1'b1;
            sel     = ID_W'(rr_idx);
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FLUSH;
         cnt_q   <= '0;
         bit_q   <= '0;
         ptr_q   <= '0;
         line_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         ptr_q   <= ptr_d;
         line_q  <= line_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_FLUSH: begin
            if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_IDLE: begin
            if (any_req) begin
               state_d = S_PRE;
               cnt_d   = '0;
               ptr_d   = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + ID_W'(1);
            end
         end
         S_PRE: begin
            if (cnt_q == CNT_W'(PRE_CYC - 1)) begin
               state_d = S_DATA;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            // 5-bit index wraps back to 0 on the last bit
            bit_d = bit_q + 5'd1;
            if (bit_q == 5'd31) begin
               state_d = S_CAPT;
            end
         end
         S_CAPT: begin
            state_d = S_GAPW;
            cnt_d   = '0;
         end
         S_GAPW: begin
            if (cnt_q == CNT_W'(GAP - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_FLUSH;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic. The serial line is registered, so its next value is
   // derived from the next state/counters to land in the right cycle.
   always_comb begin
      gnt_w  = '0;
      busy_w = 1'b0;
      line_d = 1'b0;
      if (rst) begin
         busy_w = (state_q != S_IDLE);
         if (take) begin
            gnt_w[sel] = 1'b1;
         end
      end
      case (state_d)
         S_PRE:   line_d = ~cnt_d[0];
         S_DATA:  line_d = cmd_word[bit_d];
         default: line_d = 1'b0;
      endcase
   end

   // Command latch and response registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         id_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_data_q  <= '0;
         resp_stale_q <= 1'b0;
      end else begin
         if (take) begin
            a_q  <= bus.req_a[int'(sel)*8 +: 8];
            b_q  <= bus.req_b[int'(sel)*8 +: 8];
            op_q <= bus.req_op[int'(sel)*3 +: 3];
            id_q <= sel;
         end
         resp_valid_q <= (state_q == S_CAPT);
         if (state_q == S_CAPT) begin
            resp_data_q  <= bus.alu_res_out;
            resp_id_q    <= id_q;
            resp_stale_q <= (op_q >= 3'd5);
         end
      end
   end

   assign bus.gnt         = gnt_w;
   assign bus.busy        = busy_w;
   assign bus.alu_data_in = line_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_id     = resp_id_q;
   assign bus.resp_data   = resp_data_q;
   assign bus.resp_stale  = resp_stale_q;

endmodule
`default_nettype wire
